// File: rtl/icb_acc_slave.sv
// ICB responder for the accelerator: decodes a 4 KB window into an operand
// buffer port plus CONTROL/STATUS registers, one outstanding command at a time.
module icb_acc_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
  parameter int unsigned BUF_WORDS = 960
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_addr,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        buf_we,
  output logic        buf_re,
  output logic [9:0]  buf_addr,
  output logic [31:0] buf_wdata,
  output logic [3:0]  buf_wmask,
  input  logic [31:0] buf_rdata,
  output logic        acc_start,
  input  logic        acc_busy,
  input  logic        acc_done,
  output logic        irq
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OW  = 12;
  localparam int unsigned BAW = 10;
  localparam logic [OW-1:0] CTRL_OFF = 12'hF00;
  localparam logic [OW-1:0] STAT_OFF = 12'hF04;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t           state;
  logic             irq_en;
  logic             done_sticky;

  logic [OW-1:0]    offset;
  logic [BAW-1:0]   word_idx;
  logic             hit;
  logic             aligned;
  logic             is_buf;
  logic             is_ctrl;
  logic             is_stat;
  logic             cmd_wr;
  logic             start_req;
  logic             cmd_err;
  logic             accept;
  logic             cmd_ok;
  logic             buf_rd_ok;
  logic             ctrl_wr;
  logic             stat_clr;
  logic [DW-1:0]    reg_rdata;

  // Address decode of the command currently presented on the bus
  assign offset    = icb_cmd_addr[OW-1:0];
  assign word_idx  = offset[OW-1:2];
  assign hit       = (icb_cmd_addr[31:12] == BASE_ADDR[31:12]);
  assign aligned   = (offset[1:0] == 2'b00);
  assign is_buf    = (32'(word_idx) < BUF_WORDS);
  assign is_ctrl   = !is_buf && (offset == CTRL_OFF);
  assign is_stat   = !is_buf && (offset == STAT_OFF);
  assign cmd_wr    = !icb_cmd_read;
  assign start_req = cmd_wr && is_ctrl && icb_cmd_wmask[0] && icb_cmd_wdata[0];

  assign cmd_err = !hit || !aligned || !(is_buf || is_ctrl || is_stat) ||
                   (acc_busy && cmd_wr && is_buf) ||
                   (acc_busy && start_req);

  assign accept    = icb_cmd_valid && icb_cmd_ready && !rst;
  assign cmd_ok    = accept && !cmd_err;
  assign buf_rd_ok = cmd_ok && icb_cmd_read && is_buf;
  assign ctrl_wr   = cmd_ok && cmd_wr && is_ctrl && icb_cmd_wmask[0];
  assign stat_clr  = cmd_ok && cmd_wr && is_stat && icb_cmd_wmask[0] && icb_cmd_wdata[1];

  // Buffer and start strobes fire in the accept cycle so the side effect lands on the accept edge
  assign buf_we    = cmd_ok && cmd_wr && is_buf && (icb_cmd_wmask != 4'b0000);
  assign buf_re    = buf_rd_ok;
  assign acc_start = cmd_ok && start_req;
  assign buf_addr  = (buf_we || buf_re) ? word_idx : BAW'(0);
  assign buf_wdata = buf_we ? icb_cmd_wdata : DW'(0);
  assign buf_wmask = buf_we ? icb_cmd_wmask : 4'b0000;

  assign reg_rdata = is_ctrl ? {30'b0, irq_en, 1'b0}
                             : {29'b0, 1'b0, done_sticky, acc_busy};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      icb_cmd_ready <= 1'b1;
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= DW'(0);
      icb_rsp_err   <= 1'b0;
      irq_en        <= 1'b0;
      done_sticky   <= 1'b0;
      irq           <= 1'b0;
    end else begin
      irq <= done_sticky & irq_en;

      // A completion pulse in the same cycle as the W1C keeps the sticky bit set
      if (acc_done) begin
        done_sticky <= 1'b1;
      end else if (stat_clr) begin
        done_sticky <= 1'b0;
      end

      if (ctrl_wr) begin
        irq_en <= icb_cmd_wdata[1];
      end

      case (state)
        IDLE: begin
          if (accept) begin
            icb_cmd_ready <= 1'b0;
            icb_rsp_err   <= cmd_err;
            icb_rsp_rdata <= (!cmd_err && icb_cmd_read && !is_buf) ? reg_rdata : DW'(0);
            if (buf_rd_ok) begin
              state <= RD_WAIT;
            end else begin
              state         <= RSP;
              icb_rsp_valid <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          icb_rsp_rdata <= buf_rdata;
          icb_rsp_valid <= 1'b1;
          state         <= RSP;
        end
        RSP: begin
          if (icb_rsp_ready) begin
            icb_rsp_valid <= 1'b0;
            icb_rsp_rdata <= DW'(0);
            icb_rsp_err   <= 1'b0;
            icb_cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          icb_cmd_ready <= 1'b1;
          icb_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icb_acc_slave.sv
// Bench for icb_acc_slave: directed scenarios plus random commands checked
// against a byte-level model of the window, buffer and register bits.
module tb_icb_acc_slave;

  localparam logic [31:0] BASE = 32'h1004_2000;
  localparam int unsigned NWORDS = 960;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        buf_we;
  logic        buf_re;
  logic [9:0]  buf_addr;
  logic [31:0] buf_wdata;
  logic [3:0]  buf_wmask;
  logic [31:0] buf_rdata;
  logic        acc_start;
  logic        acc_busy;
  logic        acc_done;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Memory attached to the buffer port, and the model's own view of it
  logic [31:0] ext_mem [0:1023];
  logic [31:0] m_mem   [0:1023];
  logic        m_en;
  logic        m_sticky;

  icb_acc_slave #(.BASE_ADDR(BASE), .BUF_WORDS(NWORDS)) dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .buf_we(buf_we), .buf_re(buf_re), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_wmask(buf_wmask), .buf_rdata(buf_rdata),
    .acc_start(acc_start), .acc_busy(acc_busy), .acc_done(acc_done), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_we) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_wmask[b]) ext_mem[buf_addr][8*b +: 8] <= buf_wdata[8*b +: 8];
      end
    end
    buf_rdata <= buf_re ? ext_mem[buf_addr] : 32'hBAD0_0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One command with rsp_ready held high; expectations come from the model
  task automatic txn(input string tag, input logic rd, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] wm, input logic done);
    logic win, in_buf, is_c, is_s;
    logic e_err, e_we, e_re, e_st;
    logic [31:0] e_rdata;
    int off, e_lat, lat;
    win    = (addr >= BASE) && (addr < BASE + 32'h1000);
    off    = win ? int'(addr - BASE) : 0;
    in_buf = win && (off < int'(NWORDS) * 4);
    is_c   = win && (off == 'hF00);
    is_s   = win && (off == 'hF04);
    e_err  = !win || (off % 4 != 0) || !(in_buf || is_c || is_s) ||
             (!rd && acc_busy && (in_buf || (is_c && wm[0] && wd[0])));
    e_we = 1'b0; e_re = 1'b0; e_st = 1'b0; e_rdata = 32'h0; e_lat = 1;
    if (!e_err) begin
      if (rd) begin
        if (in_buf) begin
          e_re = 1'b1; e_lat = 2; e_rdata = m_mem[off / 4];
        end else if (is_c) begin
          e_rdata = m_en ? 32'h2 : 32'h0;
        end else begin
          e_rdata = (m_sticky ? 32'h2 : 32'h0) + (acc_busy ? 32'h1 : 32'h0);
        end
      end else if (in_buf) begin
        e_we = (wm != 4'h0);
        for (int b = 0; b < 4; b++) begin
          if (wm[b]) m_mem[off / 4][8*b +: 8] = wd[8*b +: 8];
        end
      end else if (is_c && wm[0]) begin
        e_st = wd[0];
        m_en = wd[1];
      end else if (is_s && wm[0] && wd[1]) begin
        m_sticky = 1'b0;
      end
    end
    if (done) m_sticky = 1'b1;

    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wd; icb_cmd_wmask = wm; acc_done = done;
    #1;
    chk({tag, ".cmd_ready"}, 32'(icb_cmd_ready), 32'h1);
    chk({tag, ".buf_we"}, 32'(buf_we), 32'(e_we));
    chk({tag, ".buf_re"}, 32'(buf_re), 32'(e_re));
    chk({tag, ".acc_start"}, 32'(acc_start), 32'(e_st));
    if (e_we || e_re) chk({tag, ".buf_addr"}, 32'(buf_addr), 32'(off / 4));
    if (e_we) begin
      chk({tag, ".buf_wdata"}, buf_wdata, wd);
      chk({tag, ".buf_wmask"}, 32'(buf_wmask), 32'(wm));
    end
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0; acc_done = 1'b0;
    lat = 1;
    while (!icb_rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ".rsp_err"}, 32'(icb_rsp_err), 32'(e_err));
    chk({tag, ".rsp_rdata"}, icb_rsp_rdata, e_rdata);
    @(negedge clk);
    chk({tag, ".rsp_done"}, 32'(icb_rsp_valid), 32'h0);
    chk({tag, ".irq"}, 32'(irq), 32'(m_sticky & m_en));
  endtask

  initial begin
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  wm;
    logic        rd, dn;
    int          k, word;

    for (int i = 0; i < 1024; i++) begin
      ext_mem[i] = 32'h0;
      m_mem[i]   = 32'h0;
    end
    m_en = 1'b0; m_sticky = 1'b0;
    rst = 1'b1; icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = 32'h0;
    icb_cmd_wdata = 32'h0; icb_cmd_wmask = 4'h0; icb_rsp_ready = 1'b1;
    acc_busy = 1'b0; acc_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.cmd_ready", 32'(icb_cmd_ready), 32'h1);
    chk("rst.rsp_valid", 32'(icb_rsp_valid), 32'h0);
    chk("rst.rsp_rdata", icb_rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(icb_rsp_err), 32'h0);
    chk("rst.strobes", {29'h0, buf_we, buf_re, acc_start}, 32'h0);
    chk("rst.buf_bus", {buf_addr, buf_wmask, 18'h0} | buf_wdata, 32'h0);
    chk("rst.irq", 32'(irq), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    txn("wr_buf2", 1'b0, 32'h1004_2008, 32'hDEAD_BEEF, 4'hF, 1'b0);
    txn("rd_buf2", 1'b1, 32'h1004_2008, 32'h0, 4'h0, 1'b0);
    txn("wr_start", 1'b0, 32'h1004_2F00, 32'h1, 4'hF, 1'b0);
    txn("rd_ctrl0", 1'b1, 32'h1004_2F00, 32'h0, 4'h0, 1'b0);
    acc_busy = 1'b1;
    txn("wr_busy", 1'b0, 32'h1004_2010, 32'h1234_5678, 4'hF, 1'b0);
    txn("rd_stat_busy", 1'b1, 32'h1004_2F04, 32'h0, 4'h0, 1'b0);
    txn("start_busy", 1'b0, 32'h1004_2F00, 32'h1, 4'h1, 1'b0);
    txn("rd_buf_busy", 1'b1, 32'h1004_2008, 32'h0, 4'h0, 1'b0);
    acc_busy = 1'b0;
    txn("rd_buf4_clean", 1'b1, 32'h1004_2010, 32'h0, 4'h0, 1'b0);
    txn("wr_irq_en", 1'b0, 32'h1004_2F00, 32'h2, 4'h1, 1'b0);
    txn("rd_stat_done", 1'b1, 32'h1004_2F04, 32'h0, 4'h0, 1'b1);
    txn("rd_stat_sticky", 1'b1, 32'h1004_2F04, 32'h0, 4'h0, 1'b0);
    txn("w1c_vs_done", 1'b0, 32'h1004_2F04, 32'h2, 4'h1, 1'b1);
    txn("rd_stat_kept", 1'b1, 32'h1004_2F04, 32'h0, 4'h0, 1'b0);
    txn("w1c_clear", 1'b0, 32'h1004_2F04, 32'h2, 4'h1, 1'b0);
    txn("rd_stat_clr", 1'b1, 32'h1004_2F04, 32'h0, 4'h0, 1'b0);
    txn("rd_unmapped", 1'b1, 32'h1004_2F08, 32'h0, 4'h0, 1'b0);
    txn("rd_miss", 1'b1, 32'h1004_3000, 32'h0, 4'h0, 1'b0);
    txn("rd_misalign", 1'b1, 32'h1004_2001, 32'h0, 4'h0, 1'b0);
    txn("wr_mask0", 1'b0, 32'h1004_2008, 32'hFFFF_FFFF, 4'h0, 1'b0);
    txn("wr_last", 1'b0, 32'h1004_2EFC, 32'hA5A5_5A5A, 4'h5, 1'b0);
    txn("rd_last", 1'b1, 32'h1004_2EFC, 32'h0, 4'h0, 1'b0);
    txn("rd_below", 1'b1, 32'h1004_1FFC, 32'h0, 4'h0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      k        = int'($urandom_range(0, 9));
      acc_busy = ($urandom_range(0, 3) == 0);
      dn       = ($urandom_range(0, 7) == 0);
      wd       = $urandom;
      wm       = 4'($urandom);
      word     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NWORDS - 1))
                                             : int'($urandom_range(0, 15));
      a        = BASE + 32'(word * 4);
      rd       = 1'b0;
      case (k)
        0, 1, 2: rd = 1'b0;
        3, 4, 5: rd = 1'b1;
        6: begin a = BASE + 32'hF00; wd = 32'($urandom_range(0, 3)); end
        7: begin a = BASE + 32'hF04; rd = 1'($urandom_range(0, 1)); end
        8: begin a = BASE + 32'hF00; rd = 1'b1; end
        default: begin
          a  = ($urandom_range(0, 1) == 0) ? BASE + 32'($urandom_range(0, 4095)) : $urandom;
          rd = 1'($urandom_range(0, 1));
        end
      endcase
      txn("rand", rd, a, wd, wm, dn);
    end
    acc_busy = 1'b0;

    // Make irq high, then stall a read response and reset in the middle of it
    txn("pre_stall_en", 1'b0, 32'h1004_2F00, 32'h2, 4'h1, 1'b1);
    icb_rsp_ready = 1'b0;
    exp_rd = m_mem[2];
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h1004_2008;
    #1;
    chk("stall.buf_re", 32'(buf_re), 32'h1);
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    chk("stall.rsp_valid", 32'(icb_rsp_valid), 32'h1);
    chk("stall.rsp_rdata", icb_rsp_rdata, exp_rd);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall.hold_valid", 32'(icb_rsp_valid), 32'h1);
      chk("stall.hold_rdata", icb_rsp_rdata, exp_rd);
      chk("stall.cmd_ready", 32'(icb_cmd_ready), 32'h0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.rsp_valid", 32'(icb_rsp_valid), 32'h0);
    chk("midrst.cmd_ready", 32'(icb_cmd_ready), 32'h1);
    chk("midrst.irq", 32'(irq), 32'h0);
    m_en = 1'b0; m_sticky = 1'b0;
    @(negedge clk);
    rst = 1'b0; icb_rsp_ready = 1'b1;
    @(negedge clk);
    txn("post_rst_stat", 1'b1, 32'h1004_2F04, 32'h0, 4'h0, 1'b0);
    txn("post_rst_ctrl", 1'b1, 32'h1004_2F00, 32'h0, 4'h0, 1'b0);
    txn("post_rst_buf", 1'b1, 32'h1004_2008, 32'h0, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
